panda_pipe_ctrl: RTL
====================

PANDA_PIPE_CTRL -- requirements
Module: panda_pipe_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 5, register address width.
- MEM_STAGES, 1, memory stages between EX and WB; legal range 1..3.
- FWD_EN, 1, enables forwarding: 1 = forward, 0 = stall on every RAW hazard except WB.
- CNT_W, 32, performance counter width.
REQ-002 Derived: N = MEM_STAGES+2 tracked stages, index 0 = EX, 1..MEM_STAGES = M1..Mk, N-1 = WB; SEL_W = $clog2(N+1).
REQ-003 Ports (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous active-high reset.
- if_valid_i, in, 1, IF presents a valid instruction.
- id_rs1_addr_i, in, ADDR_W, rs1 of the instruction in ID.
- id_rs1_used_i, in, 1, rs1 is read.
- id_rs2_addr_i, in, ADDR_W, rs2 of the instruction in ID.
- id_rs2_used_i, in, 1, rs2 is read.
- id_rd_addr_i, in, ADDR_W, rd of the instruction in ID.
- id_rd_we_i, in, 1, the instruction in ID writes rd.
- id_is_load_i, in, 1, the instruction in ID is a load.
- ex_redirect_i, in, 1, taken branch or jump in EX.
- ext_stall_i, in, 1, external freeze of the whole pipeline.
- pc_hold_o, out, 1, hold PC and IF/ID.
- if_id_flush_o, out, 1, clear IF/ID.
- id_ex_bubble_o, out, 1, load a bubble into ID/EX.
- id_valid_o, out, 1, IF/ID holds a valid instruction.
- stage_valid_o, out, N, valid bits of EX..WB.
- fwd_a_sel_o, out, SEL_W, rs1 source.
- fwd_b_sel_o, out, SEL_W, rs2 source.
- stall_cycles_o, out, CNT_W, count of hazard stall cycles.
- flush_count_o, out, CNT_W, count of redirects.

Function
REQ-004 Per tracked stage the block SHALL keep a shadow entry {valid, rd_addr, rd_we, is_load}, plus id_valid.
REQ-005 Match(s, rsX) SHALL mean: entry s valid, rd_we set, rd_addr == rsX, rsX != 0, and rsX used.
REQ-006 Forward select SHALL be 0 = register file, s+1 = stage s; the lowest-index (youngest) match wins.
REQ-007 With FWD_EN=1, a match SHALL cause a hazard stall if the entry is a load in stages 0..MEM_STAGES-1; otherwise that stage is selected.
REQ-008 With FWD_EN=0, any match in stages 0..MEM_STAGES SHALL cause a hazard stall; a WB match is selected (N).
REQ-009 hazard = id_valid AND (any rs1 or rs2 stall condition).
REQ-010 While ext_stall_i=1:
- pc_hold_o=1, and the other control outputs are 0.
- No entry, id_valid or counter changes.
- ex_redirect_i is ignored.
REQ-011 If ext_stall_i=0 and ex_redirect_i=1:
- if_id_flush_o=1 and id_ex_bubble_o=1, and pc_hold_o=0.
- Next cycle: EX entry invalid, id_valid=0, stages 1..N-1 shift.
- flush_count_o increments by 1.
- Redirect has priority over hazard, and stall_cycles_o does not increment.
REQ-012 If ext_stall_i=0, no redirect, and hazard=1:
- pc_hold_o=1 and id_ex_bubble_o=1.
- Next cycle: EX entry invalid, id_valid held, stages 1..N-1 shift.
- stall_cycles_o increments by 1.
REQ-013 Otherwise all entries SHALL shift, EX loads {id_valid, ID fields}, and id_valid loads if_valid_i; all outputs are 0.
REQ-014 The WB entry SHALL drop out on shift; counters wrap modulo 2^CNT_W.
REQ-015 Forward selects SHALL be combinational and valid in every cycle; they are 0 when id_valid=0.

Reset
REQ-016 rst_i sampled high SHALL clear all valids, id_valid, shadow fields and both counters at that edge, including mid-stall or mid-redirect.
REQ-017 While rst_i is high, pc_hold_o, if_id_flush_o and id_ex_bubble_o SHALL be 0.

Verification
REQ-018 Scenarios use MEM_STAGES=1 (N=3, WB sel=3) unless stated otherwise.
REQ-019 ALU forward: add x5 in EX, ID reads rs1=x5 -> fwd_a_sel_o=1, no stall, stall_cycles_o=0.
REQ-020 Load-use: lw x6 in EX, ID reads rs2=x6 -> one bubble, pc_hold_o for 1 cycle, then fwd_b_sel_o=2, stall_cycles_o=1; with MEM_STAGES=3 -> 3 stall cycles, then sel=4.
REQ-021 Redirect plus hazard in the same cycle -> if_id_flush_o=1, pc_hold_o=0, flush_count_o=1, stall_cycles_o=0, id_valid_o=0 next cycle.
REQ-022 FWD_EN=0: add x7 then dependent add x7 -> 2 stall cycles, then fwd_a_sel_o=3; rd=x0 producer -> no stall, sel=0.
REQ-023 ext_stall_i high for 3 cycles during a load-use -> stage_valid_o and counters frozen; resumes with an identical sequence after release.
REQ-024 rst_i asserted during a hazard stall -> next cycle stage_valid_o=0, id_valid_o=0, both counters 0, sels 0.

Source files
------------

// File: rtl/panda_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : panda_pipe_ctrl
//  Description : In-order pipeline hazard controller. Tracks a shadow copy of
//                the destination info for EX..WB, picks operand forwarding
//                sources, inserts load-use/RAW stalls, handles redirects and
//                external freezes, and counts stall and flush events.
//  Revision    : 1.0 - initial release
// ============================================================================
module panda_pipe_ctrl #(
  parameter  int ADDR_W     = 5,
  parameter  int MEM_STAGES = 1,
  parameter  int FWD_EN     = 1,
  parameter  int CNT_W      = 32,
  localparam int N          = MEM_STAGES + 2,
  localparam int SEL_W      = $clog2(N + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] id_rs1_addr_i,
  input  logic              id_rs1_used_i,
  input  logic [ADDR_W-1:0] id_rs2_addr_i,
  input  logic              id_rs2_used_i,
  input  logic [ADDR_W-1:0] id_rd_addr_i,
  input  logic              id_rd_we_i,
  input  logic              id_is_load_i,
  input  logic              ex_redirect_i,
  input  logic              ext_stall_i,
  output logic              pc_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic              id_valid_o,
  output logic [N-1:0]      stage_valid_o,
  output logic [SEL_W-1:0]  fwd_a_sel_o,
  output logic [SEL_W-1:0]  fwd_b_sel_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_count_o
);

  // Stages where a loaded value is not yet available (EX..M(k-1)).
  localparam logic [N-1:0] c_LD_STALL_MASK = {N{1'b1}} >> (N - MEM_STAGES);
  // Without forwarding only WB (written back via regfile bypass) is usable.
  localparam logic [N-1:0] c_NOFWD_MASK    = {N{1'b1}} >> 1;

  logic [N-1:0]      valid_q, valid_d;
  logic [N-1:0]      we_q, we_d;
  logic [N-1:0]      load_q, load_d;
  logic [ADDR_W-1:0] rd_q [N];
  logic [ADDR_W-1:0] rd_d [N];
  logic              id_valid_q, id_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [N-1:0]      match_a_w, match_b_w;
  logic [N-1:0]      stall_stage_w;
  logic              stall_a_w, stall_b_w, hazard_w;
  logic [SEL_W-1:0]  sel_a_w, sel_b_w;
  logic              pc_hold_w, flush_w, bubble_w;

  // Per-stage RAW match of each ID source against the shadow entries.
  for (genvar s = 0; s < N; s++) begin : g_match
    assign match_a_w[s] = valid_q[s] & we_q[s] & (rd_q[s] == id_rs1_addr_i) &
                          (id_rs1_addr_i != '0) & id_rs1_used_i;
    assign match_b_w[s] = valid_q[s] & we_q[s] & (rd_q[s] == id_rs2_addr_i) &
                          (id_rs2_addr_i != '0) & id_rs2_used_i;
  end

  assign stall_stage_w = (FWD_EN != 0) ? (load_q & c_LD_STALL_MASK) : c_NOFWD_MASK;

  // Youngest match decides source; a stalling youngest match yields select 0.
  always_comb begin
    sel_a_w   = '0;
    sel_b_w   = '0;
    stall_a_w = 1'b0;
    stall_b_w = 1'b0;
    for (int s = N - 1; s >= 0; s--) begin
      if (match_a_w[s]) begin
        stall_a_w = stall_stage_w[s];
        sel_a_w   = SEL_W'(s + 1);
      end
      if (match_b_w[s]) begin
        stall_b_w = stall_stage_w[s];
        sel_b_w   = SEL_W'(s + 1);
      end
    end
    if (stall_a_w || !id_valid_q) sel_a_w = '0;
    if (stall_b_w || !id_valid_q) sel_b_w = '0;
  end

  assign hazard_w = id_valid_q & (stall_a_w | stall_b_w);

  // Next-state of shadow entries, counters and pipeline control outputs.
  always_comb begin
    valid_d     = valid_q;
    we_d        = we_q;
    load_d      = load_q;
    rd_d        = rd_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_hold_w   = 1'b0;
    flush_w     = 1'b0;
    bubble_w    = 1'b0;
    if (ext_stall_i) begin
      pc_hold_w = 1'b1;
    end else begin
      valid_d[N-1:1] = valid_q[N-2:0];
      we_d[N-1:1]    = we_q[N-2:0];
      load_d[N-1:1]  = load_q[N-2:0];
      for (int s = 1; s < N; s++) rd_d[s] = rd_q[s-1];
      if (ex_redirect_i) begin
        flush_w     = 1'b1;
        bubble_w    = 1'b1;
        valid_d[0]  = 1'b0;
        we_d[0]     = 1'b0;
        load_d[0]   = 1'b0;
        rd_d[0]     = '0;
        id_valid_d  = 1'b0;
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (hazard_w) begin
        pc_hold_w   = 1'b1;
        bubble_w    = 1'b1;
        valid_d[0]  = 1'b0;
        we_d[0]     = 1'b0;
        load_d[0]   = 1'b0;
        rd_d[0]     = '0;
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        valid_d[0]  = id_valid_q;
        we_d[0]     = id_rd_we_i;
        load_d[0]   = id_is_load_i;
        rd_d[0]     = id_rd_addr_i;
        id_valid_d  = if_valid_i;
      end
    end
  end

  // State register with synchronous reset overriding any stall or redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      we_q        <= '0;
      load_q      <= '0;
      for (int s = 0; s < N; s++) rd_q[s] <= '0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_hold_o      = pc_hold_w & ~rst_i;
  assign if_id_flush_o  = flush_w & ~rst_i;
  assign id_ex_bubble_o = bubble_w & ~rst_i;
  assign id_valid_o     = id_valid_q;
  assign stage_valid_o  = valid_q;
  assign fwd_a_sel_o    = sel_a_w;
  assign fwd_b_sel_o    = sel_b_w;
  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

endmodule
`default_nettype wire
